adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined multi-bit adder/subtractor built as the successor to our 1-bit full adder. Operands of WIDTH bits are split into STAGES equal slices. Each pipeline stage performs one slice of the ripple-carry sum and registers its carry into the next stage. The block sits between operand producers and result consumers and uses valid/ready handshakes on both sides, so it can be dropped into streaming datapaths.

## Interface
- WIDTH, default 16: operand and result width in bits. Must be ≥1.
- STAGES, default 4: number of pipeline stages, which is also the latency. Must satisfy 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0. SLICE = WIDTH/STAGES.
- clk  input  1  the single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  0 = add, 1 = subtract (B inverted).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.

## Operation
- Effective operation: {cout,sum} = a + (sub ? ~b : b) + cin, computed modulo 2^(WIDTH+1). Subtract with borrow-free semantics requires cin=1 (a−b). With cin=0 and sub=1 the result is a−b−1.
- ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), where b_eff = sub ? ~b : b.
- Stage k (0..STAGES-1) adds slice k of a and b_eff plus the carry registered by stage k−1. Stage 0 uses cin as its carry-in.
- Slice k+1..STAGES-1 operand bits travel through skew registers alongside the beat. Completed lower sum slices travel through de-skew registers, so all WIDTH sum bits, cout and ovf emerge together at the last stage.
- Each stage holds a valid bit. The pipeline has a single global advance: adv = !out_valid || out_ready. in_ready = adv.
- When adv=1, every stage loads from its predecessor, and stage 0 loads {in_valid, operands}. When adv=0, all stage registers hold their values, including data and valid.
- A beat is accepted when in_valid && in_ready. A beat is delivered when out_valid && out_ready.
- Bubbles (invalid stages) are not collapsed. They advance with the pipe.
- sub and cin are sampled with the beat. Beats with different modes may be interleaved back to back.
- Data registers of invalid stages may hold any value. Outputs sum/cout/ovf are only meaningful while out_valid=1.

## Timing
- Reset (rst_n=0, asynchronous): all stage valid bits clear to 0, so out_valid=0 and in_ready=1. sum, cout, ovf and all data registers clear to 0.
- Deassertion of rst_n is applied synchronously by the parent. The first beat can be accepted on the first rising edge after release.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES−1 when STAGES>1 and the pipe never stalls. That makes STAGES register stages; with STAGES=1 the result is visible in the cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 forces in_ready=0 in the same cycle (combinational). All stages freeze and no beat is lost or duplicated.
- Simultaneous delivery and acceptance in one cycle is legal and required.
- in_valid while in_ready=0: the source holds the beat stable. The block does not sample it.
- Reset mid-operation drops all in-flight beats. No partial results are presented afterwards.
- Wrap-around: carry out of bit WIDTH-1 appears only on cout. sum wraps modulo 2^WIDTH.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, in_ready=1, sum=0, cout=0, ovf=0. Release rst_n → the first beat is accepted on the next edge.
- WIDTH=8, STAGES=2, add: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0, out_valid exactly 2 edges after acceptance. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
- Subtract: sub=1, cin=1, a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- Streaming: 64 back-to-back random beats with out_ready=1 and mixed sub/cin → results match the reference model in order, one per cycle, with no gaps after the fill.
- Backpressure: random out_ready (~50%) and random in_valid bursts → in_ready == (!out_valid || out_ready) every cycle. Beat count in equals count out, with order and values preserved.
- Parameter sweep (WIDTH,STAGES) ∈ {(1,1),(8,8),(16,4),(32,1)}: exhaustive or random vectors → correct sum/cout/ovf and latency == STAGES. Assert rst_n mid-stream → out_valid=0 immediately and no stale beats after release.

Source files
------------

// File: rtl/adder_pipe_if.sv
// Operand/result streaming bundle for adder_pipe.
// The producer/consumer side uses master; the pipeline uses slave.
interface adder_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices,
// one slice per stage, carries registered between stages.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         rst_n,
  adder_pipe_if.slave bus
);
  localparam int SLICE = WIDTH / STAGES;

  // Handshake: a beat transfers on a rising edge where valid && ready.
  // The whole pipe advances together (adv); a stalled output freezes every stage,
  // so in_ready drops combinationally while out_valid && !out_ready.
  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // *_d: what stage k loads from; *_q: what stage k currently holds.
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  assign adv          = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;

    logic [SLICE:0]   part;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic             v_r;

    if (k == 0) begin : g_src_in
      assign a_d[k] = bus.a;
      assign b_d[k] = b_eff;
      assign s_d[k] = '0;
      assign c_d[k] = bus.cin;
      assign v_d[k] = bus.in_valid;
    end else begin : g_src_prev
      assign a_d[k] = a_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign s_d[k] = s_q[k-1];
      assign c_d[k] = c_q[k-1];
      assign v_d[k] = v_q[k-1];
    end

    assign part = {1'b0, a_d[k][LO +: SLICE]}
                + {1'b0, b_d[k][LO +: SLICE]}
                + {{SLICE{1'b0}}, c_d[k]};

    // Lower slices arrive already summed; this stage fills in slice k only.
    always_comb begin
      s_next               = s_d[k];
      s_next[LO +: SLICE]  = part[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_d[k];
        c_r <= part[SLICE];
        a_r <= a_d[k];
        b_r <= b_d[k];
        s_r <= s_next;
      end
    end

    assign a_q[k] = a_r;
    assign b_q[k] = b_r;
    assign s_q[k] = s_r;
    assign c_q[k] = c_r;
    assign v_q[k] = v_r;
  end

  // Overflow is decoded from the last stage's registers, so it is glitch-free
  // and aligned with sum; after reset all three MSBs are 0, giving ovf=0.
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                         (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=8, STAGES=2): reset, latency, modes,
// streaming, backpressure and mid-stream reset against hand-computed vectors.
module tb_adder_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int NVEC   = 14;

  logic clk;
  logic rst_n;

  adder_pipe_if #(.WIDTH(WIDTH)) bus ();

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // vec entry: {a[8], b[8], cin, sub, sum[8], cout, ovf}
  logic [27:0] vec [NVEC];
  logic [9:0]  exp_q [$];
  int n_checks;
  int n_fail;
  int idx;
  int send_left;
  int cyc;
  int n_out;
  int n_out0;
  int first_out;
  int last_out;
  logic last_ov;
  logic [31:0] ir_pat;
  logic [31:0] or_pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at negedge, then check handshake and delivery for the
  // upcoming rising edge, and record the accepted beat's expected result.
  task automatic step(input logic iv, input logic ordy);
    int vi;
    logic [9:0] got;
    @(negedge clk);
    vi            = idx % NVEC;
    bus.in_valid  = iv && (send_left > 0);
    bus.a         = vec[vi][27:20];
    bus.b         = vec[vi][19:12];
    bus.cin       = vec[vi][11];
    bus.sub       = vec[vi][10];
    bus.out_ready = ordy;
    #1;
    last_ov = bus.out_valid;
    check("in_ready_rule", {31'b0, bus.in_ready}, {31'b0, (!bus.out_valid || bus.out_ready)});
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        got = {bus.sum, bus.cout, bus.ovf};
        check("result", {22'b0, got}, {22'b0, exp_q.pop_front()});
      end
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(vec[vi][9:0]);
      idx++;
      send_left--;
    end
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; idx = 0; send_left = 0; cyc = 0;
    n_out = 0; first_out = -1; last_out = 0; last_ov = 1'b0;
    ir_pat = 32'hB5C6_9E27;
    or_pat = 32'h6C93_5A3D;

    vec[0]  = {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[1]  = {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vec[2]  = {8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vec[3]  = {8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vec[4]  = {8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    vec[5]  = {8'h10, 8'h03, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b0};
    vec[6]  = {8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vec[7]  = {8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vec[8]  = {8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vec[9]  = {8'h7F, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};
    vec[10] = {8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vec[11] = {8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vec[12] = {8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vec[13] = {8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};

    // Reset held with a beat offered: nothing may be captured.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'hAA;
    bus.b         = 8'h55;
    bus.cin       = 1'b1;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_sum",       {24'b0, bus.sum},       32'd0);
    check("rst_cout",      {31'b0, bus.cout},      32'd0);
    check("rst_ovf",       {31'b0, bus.ovf},       32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors one at a time: latency STAGES edges incl. acceptance.
    for (int v = 0; v < 4; v++) begin
      idx = v;
      send_left = 1;
      step(1'b1, 1'b1);
      check("accepted", {31'b0, (send_left == 0)}, 32'd1);
      step(1'b0, 1'b1);
      check("lat_early", {31'b0, last_ov}, 32'd0);
      step(1'b0, 1'b1);
      check("lat_on_time", {31'b0, last_ov}, 32'd1);
    end

    // Back-to-back streaming with mixed modes.
    idx = 0; send_left = NVEC; first_out = -1; n_out0 = n_out;
    for (int i = 0; i < NVEC; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) step(1'b0, 1'b1);
    check("stream_count", n_out - n_out0, NVEC);
    check("stream_gap", last_out - first_out, NVEC - 1);

    // Backpressure and bursty input from fixed patterns.
    idx = 0; send_left = 2 * NVEC; n_out0 = n_out;
    for (int t = 0; t < 300 && (send_left > 0 || exp_q.size() > 0); t++)
      step(ir_pat[t % 32], or_pat[t % 32]);
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_count", n_out - n_out0, 2 * NVEC);

    // Reset mid-stream while stalled: in-flight beats vanish.
    idx = 4; send_left = 5;
    repeat (3) step(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("midrst_sum",       {24'b0, bus.sum},       32'd0);
    check("midrst_cout",      {31'b0, bus.cout},      32'd0);
    exp_q.delete();
    send_left = 0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      check("no_stale", {31'b0, last_ov}, 32'd0);
    end
    idx = 8; send_left = 3;
    repeat (3) step(1'b1, 1'b1);
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) step(1'b0, 1'b1);
    check("final_queue", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
